or_edge_capture: RTL and testbench

- Downstream consumer of the 2-input OR gate stage: samples the gate's inputs A, B and its output Y.
- Synchronises all three into the clk domain and detects each rising edge of Y.
- For each edge, buffers a record {A, B, timestamp} in a small FIFO, drained over a valid/ready handshake.
- Keeps a saturating edge count and flags overflow and functional mismatch (Y != A|B) as sticky status for the bench and for debug logic.

---
 rtl/or_cap_pkg.sv | 20 ++
 rtl/or_edge_capture_if.sv | 29 ++
 rtl/or_cap_fifo.sv | 56 +++++
 rtl/or_edge_capture.sv | 158 +++++++++++++++
 tb/tb_or_edge_capture.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/or_cap_pkg.sv
// Shared types and default parameters for the OR-gate edge capture block.
// Imported by the FIFO and the top level.
package or_cap_pkg;

  localparam int DEPTH_DEF        = 4;
  localparam int TS_W_DEF         = 8;
  localparam int MISMATCH_CYC_DEF = 2;

  typedef struct packed {
    logic                a;
    logic                b;
    logic [TS_W_DEF-1:0] stamp;
  } cap_rec_t;

  typedef enum logic {
    CHK_OK,
    CHK_RUN
  } chk_state_t;

endpackage

// File: rtl/or_edge_capture_if.sv
// Record output handshake of the edge capture block.
// The master side presents the FIFO head; the slave side accepts it with out_ready.
interface or_edge_capture_if #(
  parameter int TS_W = or_cap_pkg::TS_W_DEF
) ();

  logic            out_valid;
  logic            out_ready;
  logic            out_a;
  logic            out_b;
  logic [TS_W-1:0] out_stamp;

  modport master (
    output out_valid,
    output out_a,
    output out_b,
    output out_stamp,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_a,
    input  out_b,
    input  out_stamp,
    output out_ready
  );

endinterface

// File: rtl/or_cap_fifo.sv
// Small synchronous FIFO of capture records with no write-to-read bypass.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module or_cap_fifo
  import or_cap_pkg::*;
#(
  parameter int  DEPTH = DEPTH_DEF,
  parameter type T     = cap_rec_t
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  T     din,
  output T     dout,
  output logic full,
  output logic empty
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  T              r_mem [DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [AW:0]   r_count;
  logic          w_doPush;
  logic          w_doPop;

  assign full     = (r_count == CNT_FULL);
  assign empty    = (r_count == '0);
  assign w_doPop  = pop & ~empty;
  assign w_doPush = push & (~full | w_doPop);
  assign dout     = r_mem[r_rdPtr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; its contents are only meaningful while not empty.
  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wrPtr] <= din;
  end

endmodule

// File: rtl/or_edge_capture.sv
// Watches a 2-input OR gate: synchronises A, B, Y, records {A, B, timestamp} on each
// rising edge of Y, and keeps sticky overflow/mismatch flags plus a saturating edge count.
module or_edge_capture
  import or_cap_pkg::*;
#(
  parameter int DEPTH        = DEPTH_DEF,
  parameter int TS_W         = TS_W_DEF,
  parameter int MISMATCH_CYC = MISMATCH_CYC_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a,
  input  logic                  b,
  input  logic                  y,
  input  logic                  clr,
  or_edge_capture_if.master     out_if,
  output logic [TS_W-1:0]       edge_count,
  output logic                  overflow,
  output logic                  mismatch
);

  localparam int          CW      = $clog2(MISMATCH_CYC + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MISMATCH_CYC);
  localparam logic [CW-1:0] CNT_PRE = CW'(MISMATCH_CYC - 1);

  typedef struct packed {
    logic            a;
    logic            b;
    logic [TS_W-1:0] stamp;
  } rec_t;

  logic            r_aS1, r_aS2;
  logic            r_bS1, r_bS2;
  logic            r_yS1, r_yS2, r_yS3;
  logic [TS_W-1:0] r_ts;
  logic [TS_W-1:0] r_edgeCount;
  logic            r_overflow;
  logic            r_mismatch;
  chk_state_t      r_state;
  logic [CW-1:0]   r_runCnt;

  logic            w_edge;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;
  logic            w_valid;
  logic            w_drop;
  logic            w_disagree;
  logic            w_mmHit;
  rec_t            w_din;
  rec_t            w_dout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_aS1 <= 1'b0;
      r_aS2 <= 1'b0;
      r_bS1 <= 1'b0;
      r_bS2 <= 1'b0;
      r_yS1 <= 1'b0;
      r_yS2 <= 1'b0;
      r_yS3 <= 1'b0;
      r_ts  <= '0;
    end else begin
      r_aS1 <= a;
      r_aS2 <= r_aS1;
      r_bS1 <= b;
      r_bS2 <= r_bS1;
      r_yS1 <= y;
      r_yS2 <= r_yS1;
      r_yS3 <= r_yS2;
      r_ts  <= r_ts + 1'b1;
    end
  end

  assign w_edge  = r_yS2 & ~r_yS3;
  assign w_din   = '{a: r_aS2, b: r_bS2, stamp: r_ts};
  assign w_valid = ~w_empty;
  assign w_pop   = w_valid & out_if.out_ready;
  assign w_drop  = w_edge & w_full & ~w_pop;

  or_cap_fifo #(
    .DEPTH (DEPTH),
    .T     (rec_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_edge),
    .pop   (w_pop),
    .din   (w_din),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty)
  );

  // Record fields are forced to zero when nothing is queued, so reset shows all-zero outputs.
  assign out_if.out_valid = w_valid;
  assign out_if.out_a     = w_dout.a & w_valid;
  assign out_if.out_b     = w_dout.b & w_valid;
  assign out_if.out_stamp = w_dout.stamp & {TS_W{w_valid}};

  // A same-cycle event beats clr, so a coincident edge leaves the count at 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_edgeCount <= '0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_edge) begin
        if (clr)                    r_edgeCount <= TS_W'(1);
        else if (r_edgeCount != '1) r_edgeCount <= r_edgeCount + 1'b1;
      end else if (clr) begin
        r_edgeCount <= '0;
      end
      if (w_drop)   r_overflow <= 1'b1;
      else if (clr) r_overflow <= 1'b0;
    end
  end

  assign w_disagree = r_yS2 != (r_aS2 | r_bS2);
  assign w_mmHit    = w_disagree &
                      ((r_state == CHK_OK) ? (MISMATCH_CYC == 1) : (r_runCnt == CNT_PRE));

  // Run-length filter: only disagreement lasting MISMATCH_CYC cycles counts as a real fault.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= CHK_OK;
      r_runCnt   <= '0;
      r_mismatch <= 1'b0;
    end else begin
      case (r_state)
        CHK_OK: begin
          if (w_disagree) begin
            r_state  <= CHK_RUN;
            r_runCnt <= CW'(1);
          end
        end
        CHK_RUN: begin
          if (!w_disagree) begin
            r_state  <= CHK_OK;
            r_runCnt <= '0;
          end else if (r_runCnt != CNT_MAX) begin
            r_runCnt <= r_runCnt + 1'b1;
          end
        end
        default: begin
          r_state  <= CHK_OK;
          r_runCnt <= '0;
        end
      endcase
      if (w_mmHit)  r_mismatch <= 1'b1;
      else if (clr) r_mismatch <= 1'b0;
    end
  end

  assign edge_count = r_edgeCount;
  assign overflow   = r_overflow;
  assign mismatch   = r_mismatch;

endmodule

// File: tb/tb_or_edge_capture.sv
// Randomised scoreboard bench for or_edge_capture: stimulus pushes expected records,
// a negedge monitor pops and compares whenever a record is handed over.
module tb_or_edge_capture;

  localparam int DEPTH    = 4;
  localparam int TS_W     = 4;
  localparam int MC       = 2;
  localparam int TS_MOD   = 1 << TS_W;
  localparam int EDGE_MAX = TS_MOD - 1;

  logic            clk;
  logic            rst;
  logic            a;
  logic            b;
  logic            y;
  logic            clr;
  logic [TS_W-1:0] edgeCount;
  logic            overflow;
  logic            mismatch;

  or_edge_capture_if #(.TS_W(TS_W)) outIf ();

  or_edge_capture #(
    .DEPTH        (DEPTH),
    .TS_W         (TS_W),
    .MISMATCH_CYC (MC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .a          (a),
    .b          (b),
    .y          (y),
    .clr        (clr),
    .out_if     (outIf),
    .edge_count (edgeCount),
    .overflow   (overflow),
    .mismatch   (mismatch)
  );

  typedef struct {
    logic a;
    logic b;
    int   stamp;
  } expRec_t;

  expRec_t expQ[$];
  int      passCnt     = 0;
  int      totalCnt    = 0;
  int      poppedCnt   = 0;
  int      cyc         = 0;
  int      expEdges    = 0;
  int      readyMode   = 0;
  int      base        = 0;
  logic    expOverflow = 1'b0;
  logic    expMismatch = 1'b0;
  logic    lastY       = 1'b0;
  logic    popAtWrite  = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycles since reset release; the free-running timestamp must equal this modulo 2^TS_W.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    totalCnt++;
    if (actual == expected) passCnt++;
    else $display("[TB] FAIL %s: actual %0d, expected %0d", name, actual, expected);
  endtask

  // Monitor: every accepted handshake must match the oldest expected record.
  always @(negedge clk) begin
    if (!rst && outIf.out_valid && outIf.out_ready) begin
      poppedCnt++;
      if (expQ.size() == 0) begin
        totalCnt++;
        $display("[TB] FAIL unexpectedRecord: actual a=%0d b=%0d stamp=%0d, expected no record",
                 outIf.out_a, outIf.out_b, outIf.out_stamp);
      end else begin
        expRec_t e;
        e = expQ.pop_front();
        checkOutput("recA", int'(outIf.out_a), int'(e.a));
        checkOutput("recB", int'(outIf.out_b), int'(e.b));
        checkOutput("recStamp", int'(outIf.out_stamp), e.stamp);
      end
    end
  end

  // One cycle of stimulus; a Y rise is recorded with the stamp two cycles after it is driven.
  task automatic applyStimulus(input logic na, input logic nb, input logic ny);
    @(posedge clk);
    #1;
    if (ny && !lastY) begin
      expEdges = (expEdges < EDGE_MAX) ? expEdges + 1 : EDGE_MAX;
      if (expQ.size() >= DEPTH && !popAtWrite) expOverflow = 1'b1;
      else expQ.push_back('{a: na, b: nb, stamp: (cyc + 2) % TS_MOD});
    end
    case (readyMode)
      0:       outIf.out_ready = 1'b0;
      1:       outIf.out_ready = 1'b1;
      default: outIf.out_ready = (expQ.size() >= 2) ? 1'b1 : 1'($urandom_range(0, 1));
    endcase
    a     = na;
    b     = nb;
    y     = ny;
    lastY = ny;
  endtask

  task automatic hold(input int n);
    repeat (n) applyStimulus(a, b, y);
  endtask

  task automatic pulse(input logic na, input logic nb, input int hi, input int lo);
    applyStimulus(na, nb, 1'b1);
    hold(hi - 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    hold(lo - 1);
  endtask

  task automatic randomPulse(input int hi, input int lo);
    logic na;
    logic nb;
    na = 1'($urandom_range(0, 1));
    nb = na ? 1'($urandom_range(0, 1)) : 1'b1;
    pulse(na, nb, hi, lo);
  endtask

  task automatic holdMismatch(input int n);
    applyStimulus(1'b1, 1'b0, 1'b0);
    hold(n - 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    if (n >= MC) expMismatch = 1'b1;
  endtask

  task automatic doClr();
    @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    expEdges    = 0;
    expOverflow = 1'b0;
    expMismatch = 1'b0;
  endtask

  task automatic checkStatus(input string tag);
    checkOutput({tag, "_edgeCount"}, int'(edgeCount), expEdges);
    checkOutput({tag, "_overflow"}, int'(overflow), int'(expOverflow));
    checkOutput({tag, "_mismatch"}, int'(mismatch), int'(expMismatch));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_valid"}, int'(outIf.out_valid), 0);
    checkOutput({tag, "_a"}, int'(outIf.out_a), 0);
    checkOutput({tag, "_b"}, int'(outIf.out_b), 0);
    checkOutput({tag, "_stamp"}, int'(outIf.out_stamp), 0);
    checkOutput({tag, "_edgeCount"}, int'(edgeCount), 0);
    checkOutput({tag, "_overflow"}, int'(overflow), 0);
    checkOutput({tag, "_mismatch"}, int'(mismatch), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual still running, expected finish before 200000 ns");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0] seqPat [6];
    seqPat = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b10};
    rst = 1'b1;
    a   = 1'b0;
    b   = 1'b0;
    y   = 1'b0;
    clr = 1'b0;
    outIf.out_ready = 1'b0;
    #2;
    checkAllZero("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    $display("[TB] sequence 00,01,10,11,00,10 with Y=A|B");
    readyMode = 1;
    base = poppedCnt;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(seqPat[i][1], seqPat[i][0], |seqPat[i]);
      hold(9);
    end
    hold(6);
    checkStatus("seq");
    checkOutput("seqPopped", poppedCnt - base, 2);

    $display("[TB] overflow with out_ready low");
    doClr();
    readyMode = 0;
    base = poppedCnt;
    for (int i = 0; i < 6; i++) begin
      randomPulse(4, 4);
      checkOutput("ovfAfterPulse", int'(overflow), int'(expOverflow));
    end
    checkStatus("ovf");
    readyMode = 1;
    hold(12);
    checkOutput("ovfDrained", poppedCnt - base, 4);
    checkOutput("ovfEmpty", int'(outIf.out_valid), 0);

    $display("[TB] push and pop together while full");
    doClr();
    readyMode = 0;
    base = poppedCnt;
    for (int i = 0; i < 4; i++) randomPulse(4, 4);
    popAtWrite = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    readyMode = 1;
    applyStimulus(1'b1, 1'b1, 1'b1);
    readyMode = 0;
    popAtWrite = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    hold(6);
    checkStatus("simul");
    checkOutput("simulPoppedOne", poppedCnt - base, 1);
    readyMode = 1;
    hold(12);
    checkOutput("simulDrained", poppedCnt - base, 5);

    $display("[TB] mismatch filter");
    doClr();
    holdMismatch(1);
    hold(6);
    checkOutput("mmShortGlitch", int'(mismatch), 0);
    holdMismatch(3);
    checkOutput("mmBeforeSet", int'(mismatch), 0);
    @(posedge clk);
    #1;
    checkOutput("mmAtSecondSync", int'(mismatch), 1);
    hold(4);
    checkStatus("mm");
    doClr();
    checkOutput("mmCleared", int'(mismatch), 0);

    $display("[TB] timestamp wrap and edge count saturation");
    readyMode = 2;
    for (int i = 0; i < 16; i++) begin
      randomPulse(4 + $urandom_range(0, 3), 4 + $urandom_range(0, 3));
      checkOutput("satEdgeCount", int'(edgeCount), expEdges);
    end
    checkStatus("sat");
    readyMode = 1;
    hold(10);
    checkOutput("satDrained", expQ.size(), 0);

    $display("[TB] random A/B patterns");
    doClr();
    readyMode = 2;
    for (int i = 0; i < 30; i++) begin
      logic na;
      logic nb;
      na = 1'($urandom_range(0, 1));
      nb = 1'($urandom_range(0, 1));
      applyStimulus(na, nb, na | nb);
      hold($urandom_range(2, 5));
    end
    readyMode = 1;
    hold(12);
    checkStatus("rand");
    checkOutput("randDrained", expQ.size(), 0);

    $display("[TB] reset mid-operation");
    doClr();
    readyMode = 0;
    pulse(1'b1, 1'b0, 4, 4);
    pulse(1'b0, 1'b1, 4, 4);
    applyStimulus(1'b1, 1'b1, 1'b1);
    hold(1);
    #3;
    rst   = 1'b1;
    a     = 1'b0;
    b     = 1'b0;
    y     = 1'b0;
    lastY = 1'b0;
    expQ.delete();
    expEdges    = 0;
    expOverflow = 1'b0;
    expMismatch = 1'b0;
    #1;
    checkAllZero("midReset");
    @(posedge clk);
    #1 rst = 1'b0;
    readyMode = 1;
    base = poppedCnt;
    hold(10);
    checkOutput("rstNoRecord", poppedCnt - base, 0);
    checkOutput("rstValidLow", int'(outIf.out_valid), 0);
    pulse(1'b0, 1'b1, 4, 4);
    hold(4);
    checkOutput("rstNewRecord", poppedCnt - base, 1);
    checkStatus("post");

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
